// File: rtl/ticket_pay_ctrl.sv
// Ticket seller payment front-end: latches the price, accumulates coins, and sequences confirm/cancel.
// Defining TICKET_TIMEOUT_EN adds a PAY idle timeout that behaves like cancel.
module ticket_pay_ctrl #(
    parameter logic [3:0] PRICE0         = 4'd2,
    parameter logic [3:0] PRICE1         = 4'd3,
    parameter logic [3:0] PRICE2         = 4'd5,
    parameter logic [3:0] PRICE3         = 4'd7,
    parameter int         HOLD_CYCLES    = 4,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_valid,
    input  logic [1:0] price_sel,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       confirm,
    input  logic       cancel,
    output logic [3:0] paid,
    output logic [3:0] price,
    output logic       enough,
    output logic       change_valid,
    output logic       ticket_out,
    output logic       refund,
    output logic       coin_reject,
    output logic       busy
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PAY      = 2'd1,
        DISPENSE = 2'd2,
        REFUND   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        paid_q, paid_d;
    logic [3:0]        price_q, price_d;
    logic              change_valid_q, change_valid_d;
    logic              ticket_out_q, ticket_out_d;
    logic              refund_q, refund_d;
    logic              coin_reject_q, coin_reject_d;
    logic              coin1_prev_q, coin5_prev_q;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic       rise1, rise5, coin_any;
    logic [4:0] add5, sum5;
    logic [3:0] price_lookup;
    logic       timeout_hit;

    assign rise1    = coin1 & ~coin1_prev_q;
    assign rise5    = coin5 & ~coin5_prev_q;
    assign coin_any = rise1 | rise5;
    // Sum kept at 5 bits so an overflowing coin can be detected and rejected whole.
    assign add5     = (rise5 ? 5'd5 : 5'd0) + {4'd0, rise1};
    assign sum5     = {1'b0, paid_q} + add5;

    always_comb begin
        price_lookup = PRICE0;
        case (price_sel)
            2'd0:    price_lookup = PRICE0;
            2'd1:    price_lookup = PRICE1;
            2'd2:    price_lookup = PRICE2;
            default: price_lookup = PRICE3;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        paid_d         = paid_q;
        price_d        = price_q;
        change_valid_d = change_valid_q;
        ticket_out_d   = ticket_out_q;
        refund_d       = refund_q;
        coin_reject_d  = 1'b0;
        hold_cnt_d     = hold_cnt_q;
        case (state_q)
            IDLE: begin
                coin_reject_d = coin_any;
                if (sel_valid) begin
                    price_d = price_lookup;
                    paid_d  = 4'd0;
                    state_d = PAY;
                end
            end
            PAY: begin
                if (cancel || timeout_hit) begin
                    coin_reject_d = coin_any;
                    if (paid_q == 4'd0) begin
                        price_d = 4'd0;
                        state_d = IDLE;
                    end else begin
                        refund_d   = 1'b1;
                        hold_cnt_d = HOLD_LOAD;
                        state_d    = REFUND;
                    end
                end else if (confirm && (paid_q >= price_q)) begin
                    coin_reject_d  = coin_any;
                    change_valid_d = 1'b1;
                    ticket_out_d   = 1'b1;
                    hold_cnt_d     = HOLD_LOAD;
                    state_d        = DISPENSE;
                end else begin
                    if (sel_valid) begin
                        price_d = price_lookup;
                    end
                    if (coin_any) begin
                        if (sum5 > 5'd15) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            paid_d = sum5[3:0];
                        end
                    end
                end
            end
            DISPENSE, REFUND: begin
                coin_reject_d = coin_any;
                if (hold_cnt_q <= HOLD_W'(1)) begin
                    paid_d         = 4'd0;
                    price_d        = 4'd0;
                    change_valid_d = 1'b0;
                    ticket_out_d   = 1'b0;
                    refund_d       = 1'b0;
                    hold_cnt_d     = '0;
                    state_d        = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TICKET_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign timeout_hit = (state_q == PAY) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Any accepted coin changes paid, so paid_d != paid_q marks activity.
    always_comb begin
        to_cnt_d = '0;
        if ((state_q == PAY) && (state_d == PAY) && !sel_valid && (paid_d == paid_q)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            paid_q         <= 4'd0;
            price_q        <= 4'd0;
            change_valid_q <= 1'b0;
            ticket_out_q   <= 1'b0;
            refund_q       <= 1'b0;
            coin_reject_q  <= 1'b0;
            coin1_prev_q   <= 1'b0;
            coin5_prev_q   <= 1'b0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            paid_q         <= paid_d;
            price_q        <= price_d;
            change_valid_q <= change_valid_d;
            ticket_out_q   <= ticket_out_d;
            refund_q       <= refund_d;
            coin_reject_q  <= coin_reject_d;
            coin1_prev_q   <= coin1;
            coin5_prev_q   <= coin5;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign paid         = paid_q;
    assign price        = price_q;
    assign change_valid = change_valid_q;
    assign ticket_out   = ticket_out_q;
    assign refund       = refund_q;
    assign coin_reject  = coin_reject_q;
    assign busy         = (state_q != IDLE);
    assign enough       = (state_q == PAY) && (paid_q >= price_q);

endmodule

// File: tb/tb_ticket_pay_ctrl.sv
// Self-checking bench for ticket_pay_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_ticket_pay_ctrl;
`ifdef TICKET_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1000;
`endif
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst, sel_valid, coin1, coin5, confirm, cancel;
    logic [1:0] price_sel;
    logic [3:0] paid, price;
    logic       enough, change_valid, ticket_out, refund, coin_reject, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0=waiting, 1=collecting, 2=ticket hold, 3=refund hold.
    int m_phase, m_paid, m_price, m_hold, m_idle;
    bit m_prev1, m_prev5, m_rej;
    int prices[4] = '{2, 3, 5, 7};

    ticket_pay_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .sel_valid(sel_valid), .price_sel(price_sel),
        .coin1(coin1), .coin5(coin5), .confirm(confirm), .cancel(cancel),
        .paid(paid), .price(price), .enough(enough), .change_valid(change_valid),
        .ticket_out(ticket_out), .refund(refund), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase = 0; m_paid = 0; m_price = 0; m_hold = 0; m_idle = 0;
        m_prev1 = 0; m_prev5 = 0; m_rej = 0;
    endtask

    task automatic model_step();
        int add;
        bit timed_out, take;
        add = (coin1 && !m_prev1 ? 1 : 0) + (coin5 && !m_prev5 ? 5 : 0);
        m_prev1 = coin1;
        m_prev5 = coin5;
        m_rej = 0;
        timed_out = 0;
`ifdef TICKET_TIMEOUT_EN
        timed_out = (m_phase == 1) && (m_idle == TO - 1);
`endif
        if (m_phase == 0) begin
            m_rej = (add > 0);
            if (sel_valid) begin
                m_price = prices[price_sel]; m_paid = 0; m_phase = 1; m_idle = 0;
            end
        end else if (m_phase == 1) begin
            if (cancel || timed_out) begin
                m_rej = (add > 0);
                if (m_paid == 0) begin m_phase = 0; m_price = 0; end
                else begin m_phase = 3; m_hold = HOLD; end
            end else if (confirm && m_paid >= m_price) begin
                m_rej = (add > 0);
                m_phase = 2; m_hold = HOLD;
            end else begin
                take = (add > 0) && (m_paid + add <= 15);
                m_rej = (add > 0) && !take;
                if (take) m_paid += add;
                if (sel_valid) m_price = prices[price_sel];
                if (take || sel_valid) m_idle = 0; else m_idle++;
            end
        end else begin
            m_rej = (add > 0);
            m_hold--;
            if (m_hold == 0) begin m_phase = 0; m_paid = 0; m_price = 0; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        sel_valid = 0; confirm = 0; cancel = 0;
    endtask

    task automatic coin_pulse(input bit c1, input bit c5);
        coin1 = c1; coin5 = c5; tick();
        coin1 = 0; coin5 = 0; tick();
    endtask

    task automatic select(input logic [1:0] s);
        sel_valid = 1; price_sel = s; tick();
    endtask

    task automatic test_reset();
        rst = 1; sel_valid = 0; price_sel = 0; coin1 = 0; coin5 = 0; confirm = 0; cancel = 0;
        #1;
        checks++;
        if ({paid, price, change_valid, ticket_out, refund, coin_reject, busy, enough} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got paid=%0d price=%0d cv=%b tk=%b rf=%b rj=%b busy=%b en=%b want all 0",
                     paid, price, change_valid, ticket_out, refund, coin_reject, busy, enough);
        end
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_buy_exact();
        select(2'd2);
        checks++; if (price !== 4'd5 || busy !== 1'b1) begin errors++;
            $display("FAIL buy_select: got price=%0d busy=%b want price=5 busy=1", price, busy); end
        coin_pulse(0, 1);
        confirm = 1; tick();
        checks++; if ({change_valid, ticket_out, paid, price} !== {1'b1, 1'b1, 4'd5, 4'd5}) begin errors++;
            $display("FAIL buy_confirm: got cv=%b tk=%b paid=%0d price=%0d want 1 1 5 5", change_valid, ticket_out, paid, price); end
        for (int i = 2; i <= HOLD; i++) begin
            tick();
            checks++; if (ticket_out !== 1'b1 || change_valid !== 1'b1 || paid !== 4'd5) begin errors++;
                $display("FAIL buy_hold: cycle %0d got tk=%b cv=%b paid=%0d want 1 1 5", i, ticket_out, change_valid, paid); end
        end
        tick();
        checks++; if ({ticket_out, change_valid, busy, paid, price} !== 11'd0) begin errors++;
            $display("FAIL buy_end: got tk=%b cv=%b busy=%b paid=%0d price=%0d want all 0", ticket_out, change_valid, busy, paid, price); end
    endtask

    task automatic test_underpay();
        select(2'd1);
        coin_pulse(1, 0);
        coin_pulse(1, 0);
        checks++; if (paid !== 4'd2 || enough !== 1'b0) begin errors++;
            $display("FAIL under_paid: got paid=%0d enough=%b want 2 0", paid, enough); end
        confirm = 1; tick();
        checks++; if (change_valid !== 1'b0 || ticket_out !== 1'b0 || busy !== 1'b1 || paid !== 4'd2) begin errors++;
            $display("FAIL under_confirm_ignored: got cv=%b tk=%b busy=%b paid=%0d want 0 0 1 2", change_valid, ticket_out, busy, paid); end
        coin5 = 1; tick(); coin5 = 0;
        checks++; if (paid !== 4'd7 || enough !== 1'b1) begin errors++;
            $display("FAIL under_topup: got paid=%0d enough=%b want 7 1", paid, enough); end
        confirm = 1; tick();
        checks++; if (change_valid !== 1'b1 || paid !== 4'd7 || price !== 4'd3) begin errors++;
            $display("FAIL under_change: got cv=%b paid=%0d price=%0d want 1 7 3", change_valid, paid, price); end
        repeat (HOLD) tick();
    endtask

    task automatic test_overflow();
        select(2'd3);
        coin_pulse(0, 1); coin_pulse(0, 1); coin_pulse(1, 0); coin_pulse(1, 0);
        checks++; if (paid !== 4'd12) begin errors++;
            $display("FAIL ovf_setup: got paid=%0d want 12", paid); end
        coin5 = 1; tick(); coin5 = 0;
        checks++; if (coin_reject !== 1'b1 || paid !== 4'd12) begin errors++;
            $display("FAIL ovf_reject: got rej=%b paid=%0d want 1 12", coin_reject, paid); end
        tick();
        checks++; if (coin_reject !== 1'b0 || paid !== 4'd12) begin errors++;
            $display("FAIL ovf_reject_pulse: got rej=%b paid=%0d want 0 12", coin_reject, paid); end
        cancel = 1; tick();
        repeat (HOLD) tick();
        select(2'd0);
        coin_pulse(0, 1); coin_pulse(1, 0); coin_pulse(1, 0); coin_pulse(1, 0); coin_pulse(1, 0);
        coin1 = 1; coin5 = 1; tick(); coin1 = 0; coin5 = 0;
        checks++; if (paid !== 4'd15 || coin_reject !== 1'b0) begin errors++;
            $display("FAIL ovf_both_coins: got paid=%0d rej=%b want 15 0", paid, coin_reject); end
        tick();
        cancel = 1; tick();
        repeat (HOLD) tick();
    endtask

    task automatic test_cancel();
        select(2'd0);
        coin_pulse(1, 1);
        checks++; if (paid !== 4'd6) begin errors++;
            $display("FAIL cancel_setup: got paid=%0d want 6", paid); end
        cancel = 1; confirm = 1; tick();
        for (int i = 1; i <= HOLD; i++) begin
            checks++; if (refund !== 1'b1 || ticket_out !== 1'b0 || paid !== 4'd6 || change_valid !== 1'b0) begin errors++;
                $display("FAIL cancel_refund: cycle %0d got rf=%b tk=%b paid=%0d cv=%b want 1 0 6 0", i, refund, ticket_out, paid, change_valid); end
            tick();
        end
        checks++; if ({refund, busy, paid} !== 6'd0) begin errors++;
            $display("FAIL cancel_end: got rf=%b busy=%b paid=%0d want 0 0 0", refund, busy, paid); end
        select(2'd1);
        cancel = 1; tick();
        checks++; if (busy !== 1'b0 || refund !== 1'b0 || price !== 4'd0) begin errors++;
            $display("FAIL cancel_empty: got busy=%b rf=%b price=%0d want 0 0 0", busy, refund, price); end
    endtask

    task automatic test_reset_mid_dispense();
        select(2'd0);
        coin_pulse(0, 1);
        confirm = 1; tick();
        tick();
        #2 rst = 1;
        #1;
        checks++; if ({paid, price, change_valid, ticket_out, refund, coin_reject, busy} !== 13'd0) begin errors++;
            $display("FAIL midrst_outputs: got paid=%0d price=%0d cv=%b tk=%b rf=%b busy=%b want all 0",
                     paid, price, change_valid, ticket_out, refund, busy); end
        rst = 0;
        model_reset();
        select(2'd3);
        checks++; if (price !== 4'd7 || busy !== 1'b1 || paid !== 4'd0) begin errors++;
            $display("FAIL midrst_resume: got price=%0d busy=%b paid=%0d want 7 1 0", price, busy, paid); end
        cancel = 1; tick();
    endtask

`ifdef TICKET_TIMEOUT_EN
    task automatic test_timeout();
        select(2'd3);
        coin_pulse(1, 0);
        coin1 = 1; tick(); coin1 = 0;
        for (int i = 1; i <= 9; i++) tick();
        checks++; if (refund !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL to_early: got rf=%b busy=%b want 0 1", refund, busy); end
        coin1 = 1; tick(); coin1 = 0;
        checks++; if (paid !== 4'd3) begin errors++;
            $display("FAIL to_restart_coin: got paid=%0d want 3", paid); end
        for (int i = 11; i <= 25; i++) begin
            tick();
            if (i == 16 || i == 25) begin
                checks++; if (refund !== 1'b0) begin errors++;
                    $display("FAIL to_restarted: edge %0d got rf=%b want 0", i, refund); end
            end
        end
        tick();
        checks++; if (refund !== 1'b1 || paid !== 4'd3) begin errors++;
            $display("FAIL to_fire: got rf=%b paid=%0d want 1 3", refund, paid); end
        repeat (HOLD) tick();
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL to_end: got busy=%b want 0", busy); end
    endtask
`endif

    task automatic test_random();
        logic [15:0] got, exp;
        int          logged = 0;
        for (int n = 0; n < 1500; n++) begin
            sel_valid = ($urandom_range(0, 7) == 0);
            price_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) coin1 = ~coin1;
            if ($urandom_range(0, 3) == 0) coin5 = ~coin5;
            confirm = ($urandom_range(0, 5) == 0);
            cancel  = ($urandom_range(0, 24) == 0);
            tick();
            got = {paid, price, change_valid, ticket_out, refund, coin_reject, busy, enough, 2'b00};
            exp = {4'(m_paid), 4'(m_price), m_phase == 2, m_phase == 2, m_phase == 3, m_rej,
                   m_phase != 0, (m_phase == 1) && (m_paid >= m_price), 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                if (logged < 20) begin
                    logged++;
                    $display("FAIL random_outputs: cycle %0d got %h want %h", n, got, exp);
                end
            end
        end
        coin1 = 0; coin5 = 0;
    endtask

    initial begin
        test_reset();
        test_buy_exact();
        test_underpay();
        test_overflow();
        test_cancel();
        test_reset_mid_dispense();
`ifdef TICKET_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ticket_pay_ctrl.md
Name: ticket_pay_ctrl

Overview:
- Payment front-end of the ticket seller. Sits directly upstream of the 4-bit change subtractor.
- Latches the selected ticket price and accumulates inserted coins into a 4-bit paid amount.
- On confirm, freezes paid/price as the subtractor operands, asserts change_valid and pulses the ticket output. On cancel, refunds.
- Downstream change logic reads paid (minuend) and price (subtrahend) only while change_valid=1.

Parameters:
- PRICE0, 4'd2, price for price_sel=0
- PRICE1, 4'd3, price for price_sel=1
- PRICE2, 4'd5, price for price_sel=2
- PRICE3, 4'd7, price for price_sel=3
- HOLD_CYCLES, 4, length in cycles of the ticket_out and refund pulses (>=1)
- TIMEOUT_CYCLES, 1000, PAY idle timeout in cycles (used only with TICKET_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- sel_valid  input  1  one-cycle strobe; latch price_sel
- price_sel  input  2  ticket type
- coin1  input  1  level, synchronous to clk; each rising edge = 1 unit
- coin5  input  1  level, synchronous to clk; each rising edge = 5 units
- confirm  input  1  one-cycle strobe; buy
- cancel  input  1  one-cycle strobe; abort and refund
- paid  output  4  accumulated amount; subtractor minuend
- price  output  4  latched price; subtractor subtrahend
- enough  output  1  combinational: state==PAY and paid>=price
- change_valid  output  1  paid/price frozen and valid for change computation
- ticket_out  output  1  ticket dispense pulse
- refund  output  1  refund pulse; paid shows the amount to return
- coin_reject  output  1  one-cycle pulse; a coin was not accepted
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; paid=0; price=0; change_valid=0; ticket_out=0; refund=0; coin_reject=0; coin edge registers=0. All state and outputs are registered except enough and busy.
- Coin edge detect: rise = input & ~prev, with prev registered every cycle. Coins are accepted on the same clock edge that first samples the input high.
- Coin add: add = 1·rise1 + 5·rise5, so both coins in one cycle add 6. The sum is computed at 5 bits.
  - If paid+add > 15: paid is unchanged and coin_reject=1 for one cycle. All-or-nothing, no partial accept.
- IDLE:
  - sel_valid → price = PRICE[price_sel], paid=0, go to PAY on the next cycle.
  - Any coin edge → coin_reject pulse; paid stays 0.
  - confirm and cancel are ignored.
- PAY:
  - Coins are accepted per the add rule.
  - sel_valid re-latches price; paid is kept.
  - cancel → REFUND. cancel takes priority over confirm in the same cycle.
  - confirm with paid>=price → DISPENSE; change_valid=1 from the next cycle.
  - confirm with paid<price → ignored.
  - A coin edge in the same cycle as an accepted confirm is rejected.
  - A confirm in the same cycle as a coin uses the pre-add paid value.
- DISPENSE:
  - ticket_out=1 and change_valid=1 for exactly HOLD_CYCLES cycles.
  - paid and price are frozen. Coins are rejected; cancel, confirm and sel_valid are ignored.
  - After the last cycle: IDLE, paid=0, price=0, change_valid=0, all on the same edge.
- REFUND:
  - refund=1 for HOLD_CYCLES cycles while paid holds the refund amount. Coins are rejected.
  - After the last cycle: IDLE, paid=0, price=0.
  - If paid==0 on entry: REFUND is skipped, go directly to IDLE with no refund pulse.
- Hold counter: width clog2(HOLD_CYCLES+1). Loaded on entry to DISPENSE/REFUND; no wrap.
- Mid-operation reset: all outputs drop asynchronously to their reset values; the partial payment is discarded.

Optional Feature:
- Macro TICKET_TIMEOUT_EN.
- Defined:
  - A counter in PAY increments each cycle. It clears on PAY entry, on every accepted coin, and on sel_valid.
  - On reaching TIMEOUT_CYCLES-1, the FSM behaves as if cancel was asserted: REFUND, or IDLE if paid==0.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Not defined: no counter logic is present; PAY waits indefinitely.

Test Plan:
- Reset mid-DISPENSE (rst pulse in cycle 2 of ticket_out) → all outputs 0 immediately and state IDLE; the next sel_valid works normally.
- sel_valid, price_sel=2 → price=5. Then coin5 rise, then confirm → change_valid=1, paid=5, price=5, ticket_out high 4 cycles. After that, paid=0, busy=0.
- price_sel=1 (price 3); coin1 ×2 → enough=0, and confirm is ignored. Then coin5 → paid=7, enough=1. Then confirm → change_valid with paid=7, price=3.
- paid=12 in PAY. coin5 → coin_reject 1 cycle, paid stays 12. Then coin1+coin5 rising in the same cycle with paid=9 → paid=15.
- paid=6, cancel and confirm in the same cycle → refund high 4 cycles with paid=6, ticket_out never set. Separately, cancel with paid=0 → straight to IDLE with no refund pulse.
- With TICKET_TIMEOUT_EN and TIMEOUT_CYCLES=16: paid=3, no activity → refund asserted at cycle 16 after the last coin. A coin at cycle 10 restarts the count.
